// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and helpers for the UART receive sampler
package uart_rx_pkg;

  // Default widths: 6-bit prescale covers ratios up to 62, 4-bit bit index
  // covers start + 8 data + parity + stop.
  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = 4;

  // Supported oversampling ratios.
  localparam logic [PRESCALE_W-1:0] PS_8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] PS_16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] PS_32 = PRESCALE_W'(32);

  // Smallest ratio that still leaves room for three distinct sample points.
  localparam int PS_MIN = 4;

  // Level of the serial line when nothing is being transmitted.
  localparam logic IDLE_LEVEL = 1'b1;

  // Early and centre samples captured before the vote.
  typedef struct packed {
    logic s0;
    logic s1;
  } sample_pair_t;

  // Two-out-of-three vote; a single corrupted sample cannot flip the result.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter, bit counter and prescale latch
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W_P = PRESCALE_W,
  parameter int BIT_CNT_W_P  = BIT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PRESCALE_W_P-1:0] prescale,
  output logic [PRESCALE_W_P-1:0] ps_q,
  output logic [PRESCALE_W_P-1:0] edge_cnt,
  output logic [BIT_CNT_W_P-1:0]  bit_cnt,
  output logic                    bit_done
);

  logic [PRESCALE_W_P-1:0] ps_legal;
  logic                    last_edge;

  // Clamp tiny ratios up to the minimum and force even so mid-bit is exact.
  always_comb begin
    ps_legal = prescale;
    if (prescale < PRESCALE_W_P'(PS_MIN)) begin
      ps_legal = PRESCALE_W_P'(PS_MIN);
    end else begin
      ps_legal[0] = 1'b0;
    end
  end

  assign last_edge = (edge_cnt == (ps_q - PRESCALE_W_P'(1)));

  // Ratio is only loaded while idle so a frame always runs at one rate;
  // counters advance while enabled and clear whenever enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q     <= ps_legal;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      bit_done <= 1'b0;
    end else if (!en) begin
      ps_q     <= ps_legal;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      bit_done <= 1'b0;
    end else if (last_edge) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_CNT_W_P'(1);
      bit_done <= 1'b1;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W_P'(1);
      bit_done <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART receive front end: synchroniser, bit timing and mid-bit majority vote
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W_P = PRESCALE_W,
  parameter int BIT_CNT_W_P  = BIT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    rx_in,
  input  logic [PRESCALE_W_P-1:0] prescale,
  output logic                    sampled_bit,
  output logic                    sample_valid,
  output logic [PRESCALE_W_P-1:0] edge_cnt,
  output logic [BIT_CNT_W_P-1:0]  bit_cnt,
  output logic                    bit_done
);

  logic                    rx_meta;
  logic                    rx_s;
  logic [PRESCALE_W_P-1:0] ps_q;
  logic [PRESCALE_W_P-1:0] mid;
  logic                    cap_early;
  logic                    cap_centre;
  logic                    vote_now;
  sample_pair_t            samp;

  // Two-flop synchroniser; resets to idle so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= IDLE_LEVEL;
      rx_s    <= IDLE_LEVEL;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_edge_bit_counter #(
    .PRESCALE_W_P (PRESCALE_W_P),
    .BIT_CNT_W_P  (BIT_CNT_W_P)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .ps_q     (ps_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done)
  );

  // Sample points straddle the bit centre: mid-1, mid, and mid+1 (the vote).
  assign mid        = ps_q >> 1;
  assign cap_early  = en && (edge_cnt == (mid - PRESCALE_W_P'(1)));
  assign cap_centre = en && (edge_cnt == mid);
  assign vote_now   = en && (edge_cnt == (mid + PRESCALE_W_P'(1)));

  // Hold the two earlier samples; dropping enable discards a half-collected bit.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      samp.s0 <= IDLE_LEVEL;
      samp.s1 <= IDLE_LEVEL;
    end else begin
      if (cap_early) begin
        samp.s0 <= rx_s;
      end
      if (cap_centre) begin
        samp.s1 <= rx_s;
      end
    end
  end

  // Register the vote and strobe it once per bit; the last value survives disable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sampled_bit  <= IDLE_LEVEL;
      sample_valid <= 1'b0;
    end else if (!en) begin
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vote_now;
      if (vote_now) begin
        sampled_bit <= majority3(samp.s0, samp.s1, rx_s);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - self-checking bench for uart_rx_sampler
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rx_in;
  logic [5:0] prescale;
  logic       sampled_bit;
  logic       sample_valid;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       bit_done;

  uart_rx_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .bit_done     (bit_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       bitv;
    logic [3:0] bcnt;
    logic [5:0] ecnt;
    logic       no_overlap;
  } exp_t;

  typedef struct {
    logic [5:0]  ps_in;
    logic [5:0]  ps_mid;
    int          period;
    logic [31:0] data;
    int          nbits;
  } vec_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  vec_t  vecs[8];
  logic  wave[0:1023];
  int    n_cmp = 0;
  int    n_err = 0;
  int    bd_cnt = 0;
  logic  last_bit = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bit_done) bd_cnt++;
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sample_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sampled_bit", int'(sampled_bit), int'(mon_e.bitv));
        check("bit_cnt_at_valid", int'(bit_cnt), int'(mon_e.bcnt));
        check("edge_cnt_at_valid", int'(edge_cnt), int'(mon_e.ecnt));
        if (mon_e.no_overlap) check("valid_with_bit_done", int'(bit_done), 0);
      end
    end
  end

  // wave[t] is the desired synchronised line level in enabled cycle t.
  task automatic run_wave(input logic [5:0] ps_in, input logic [5:0] ps_mid,
                          input int period, input int nbits);
    int   n;
    int   mid;
    int   bd0;
    int   votes;
    logic maj;
    exp_t e;
    n   = period * nbits;
    mid = period / 2;
    for (int b = 0; b < nbits; b++) begin
      votes = int'(wave[b*period+mid-1]) + int'(wave[b*period+mid]) + int'(wave[b*period+mid+1]);
      maj = (votes >= 2);
      e.bitv = maj;
      e.bcnt = 4'(b + (((mid + 2) >= period) ? 1 : 0));
      e.ecnt = 6'((mid + 2) % period);
      e.no_overlap = (period >= 8);
      exp_q.push_back(e);
      last_bit = maj;
    end
    @(negedge clk);
    en = 1'b0; prescale = ps_in; rx_in = wave[0];
    @(negedge clk);
    rx_in = wave[1];
    bd0 = bd_cnt;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      en = 1'b1;
      rx_in = (t + 2 < n) ? wave[t+2] : 1'b1;
      if (t == 3) prescale = ps_mid;
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("bit_done_count", bd_cnt - bd0, nbits);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{6'd8,  6'd8,  8,  32'h0000_02AA, 10};
    vecs[1] = '{6'd16, 6'd16, 16, 32'h0000_01B3, 10};
    vecs[2] = '{6'd32, 6'd8,  32, 32'h0000_000A, 4};
    vecs[3] = '{6'd2,  6'd2,  4,  32'h0000_002D, 6};
    vecs[4] = '{6'd0,  6'd0,  4,  32'h0000_0005, 3};
    vecs[5] = '{6'd9,  6'd9,  8,  32'h0000_0006, 3};
    vecs[6] = '{6'd17, 6'd17, 16, 32'h0000_0003, 3};
    vecs[7] = '{6'd8,  6'd8,  8,  32'h0002_9C5A, 18};

    // Reset holds everything at idle values while the line toggles.
    rst = 1'b1; en = 1'b0; prescale = 6'd8; rx_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_in = ~rx_in;
      check("rst_sampled_bit", int'(sampled_bit), 1);
      check("rst_sample_valid", int'(sample_valid), 0);
      check("rst_edge_cnt", int'(edge_cnt), 0);
      check("rst_bit_cnt", int'(bit_cnt), 0);
    end
    rst = 1'b0;
    rx_in = 1'b1;

    // Table: frames at several ratios, including clamped/odd and mid-frame changes.
    for (int v = 0; v < 8; v++) begin
      for (int t = 0; t < vecs[v].period * vecs[v].nbits; t++)
        wave[t] = vecs[v].data[t / vecs[v].period];
      run_wave(vecs[v].ps_in, vecs[v].ps_mid, vecs[v].period, vecs[v].nbits);
    end

    // Single-cycle glitch at the centre sample is outvoted.
    for (int t = 0; t < 16; t++) wave[t] = 1'b1;
    wave[8] = 1'b0;
    run_wave(6'd16, 6'd16, 16, 1);
    check("glitch_1cyc_bit", int'(sampled_bit), 1);

    // Two-cycle low covering two sample points wins the vote.
    wave[7] = 1'b0;
    run_wave(6'd16, 6'd16, 16, 1);
    check("glitch_2cyc_bit", int'(sampled_bit), 0);

    // Abort: enable drops at edge 7, no strobe, counters clear, bit held.
    @(negedge clk);
    en = 1'b0; prescale = 6'd16; rx_in = ~last_bit;
    @(negedge clk);
    @(negedge clk);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      en = 1'b1;
    end
    @(negedge clk);
    check("abort_edge_before", int'(edge_cnt), 7);
    en = 1'b0;
    @(negedge clk);
    check("abort_edge_cnt", int'(edge_cnt), 0);
    check("abort_bit_cnt", int'(bit_cnt), 0);
    check("abort_sample_valid", int'(sample_valid), 0);
    check("abort_sampled_bit", int'(sampled_bit), int'(last_bit));
    repeat (20) @(negedge clk);
    check("abort_bit_held", int'(sampled_bit), int'(last_bit));

    // Reset mid-frame at bit 5, edge 3 with enable still high.
    @(negedge clk);
    en = 1'b0; prescale = 6'd8; rx_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      mon_e.bitv = 1'b1; mon_e.bcnt = 4'(b); mon_e.ecnt = 6'd6; mon_e.no_overlap = 1'b1;
      exp_q.push_back(mon_e);
    end
    for (int t = 0; t < 43; t++) begin
      @(negedge clk);
      en = 1'b1;
    end
    @(negedge clk);
    check("pre_rst_edge_cnt", int'(edge_cnt), 3);
    check("pre_rst_bit_cnt", int'(bit_cnt), 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_edge_cnt", int'(edge_cnt), 0);
    check("midrst_bit_cnt", int'(bit_cnt), 0);
    check("midrst_sampled_bit", int'(sampled_bit), 1);
    check("midrst_sample_valid", int'(sample_valid), 0);
    check("midrst_bit_done", int'(bit_done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("resume_edge_1", int'(edge_cnt), 1);
    check("resume_bit_cnt", int'(bit_cnt), 0);
    @(negedge clk);
    check("resume_edge_2", int'(edge_cnt), 2);
    en = 1'b0;
    @(negedge clk);
    check("midrst_queue_drained", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
